spi_cmd_decoder: RTL
====================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for ce0/ssig (legal 2..4).
REQ-002 SHALL have parameter VERSION, default 8'hA5, value returned by read-only register 3.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ce0  input  1  SPI chip select from host, active-low, asynchronous to clk.
REQ-006 SHALL have port ssig  input  1  byte-complete strobe from the SPI slave (sclk domain), asynchronous to clk.
REQ-007 SHALL have port rx_byte  input  8  last received byte from the SPI slave; upstream holds it stable ≥ SYNC_STAGES+2 clk cycles after ssig rises.
REQ-008 SHALL have port tx_byte  output  8  next byte for the SPI slave to shift out on MISO.
REQ-009 SHALL have port leds  output  4  drives D1..D4, equals reg0[3:0].
REQ-010 SHALL have port cmd_err  output  1  high while the current frame is in error.

Function
REQ-011 SHALL pass ce0 and ssig through SYNC_STAGES-flop synchronizers; a byte event is a synchronized ssig rising edge while synchronized ce0 is low.
REQ-012 SHALL sample rx_byte on the byte-event cycle (SYNC_STAGES+1 clk after ssig rise).
REQ-013 SHALL implement FSM states IDLE, CMD, DATA, ERR.
REQ-014 IDLE -> CMD on synchronized ce0 falling edge; tx_byte = 8'h00 in IDLE and CMD.
REQ-015 In CMD, a byte event decodes the command: bit7 = write(1)/read(0), bits[1:0] = address, bits[6:2] must be zero.
REQ-016 CMD with bits[6:2] nonzero SHALL go to ERR; otherwise go to DATA with pointer = bits[1:0].
REQ-017 On a read command, tx_byte SHALL equal reg[pointer] by the cycle after the command byte event.
REQ-018 In DATA, each byte event on a write frame writes rx_byte to reg[pointer]; on a read frame the byte is discarded.
REQ-019 In DATA, each byte event SHALL increment pointer modulo 4 (3 -> 0) and, on read frames, reload tx_byte with reg[new pointer] next cycle.
REQ-020 reg0, reg1 SHALL be read/write; writes to reg2, reg3 SHALL be ignored without error.
REQ-021 reg2 SHALL be an 8-bit completed-frame counter, wrapping 8'hFF -> 8'h00.
REQ-022 reg3 SHALL read VERSION.
REQ-023 leds SHALL update the cycle after a reg0 write.
REQ-024 ERR SHALL ignore all byte events, drive tx_byte = 8'hEE and cmd_err = 1.
REQ-025 Synchronized ce0 rising edge in any state SHALL return to IDLE next cycle and clear cmd_err.
REQ-026 reg2 SHALL increment on a ce0 rising edge leaving DATA having seen ≥1 data byte event.
REQ-027 A ce0 rising edge in the same cycle as a byte event SHALL win; that byte is dropped.
REQ-028 ce0 deassert mid-frame SHALL keep all completed writes; no partial byte is written.

Reset
REQ-029 While rst_n is low: state = IDLE, reg0 = reg1 = reg2 = 8'h00, pointer = 0, tx_byte = 8'h00, leds = 4'h0, cmd_err = 0, synchronizer flops = idle values (ce0 high, ssig low).
REQ-030 Reset deassertion with ce0 already low SHALL NOT start a frame until ce0 is seen high then low.

Structure
REQ-031 Package spi_cmd_pkg SHALL hold the FSM state enum, register address constants (REG_LED=0, REG_SCRATCH=1, REG_FRMCNT=2, REG_VER=3), ERR_BYTE = 8'hEE, IDLE_BYTE = 8'h00.
REQ-032 Synchronizer plus edge detector SHALL be one sub-module spi_rx_sync, instantiated once per async input (ce0, ssig).

Verification
REQ-033 Write frame: ce0 low, bytes 8'h80, 8'h0B, ce0 high -> leds = 4'hB, reg2 = 1, cmd_err = 0.
REQ-034 Burst write with wrap: 8'h83, 8'h11, 8'h22, 8'h33 -> reg3 write ignored, reg0 = 8'h22, reg1 = 8'h33, leds = 4'h2.
REQ-035 Read frame: 8'h03 -> tx_byte = 8'hA5 before second byte; continue -> tx_byte = reg0 after wrap.
REQ-036 Bad command 8'h44 -> cmd_err = 1, tx_byte = 8'hEE, further writes ignored; ce0 high -> IDLE, reg2 unchanged.
REQ-037 ce0 high on the same cycle as a byte event of a write frame -> byte not written, FSM IDLE next cycle.
REQ-038 rst_n low mid-frame with ce0 held low -> all outputs at reset values; no frame starts until ce0 toggles high then low.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared types and constants for the SPI command decoder: FSM states,
// register map and the fixed bytes returned on MISO.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_FRMCNT  = 2'd2;
    localparam logic [1:0] REG_VER     = 2'd3;

    localparam logic [7:0] ERR_BYTE  = 8'hEE;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    function automatic logic [7:0] reg_mux(input logic [7:0] r0,
                                           input logic [7:0] r1,
                                           input logic [7:0] r2,
                                           input logic [7:0] r3,
                                           input logic [1:0] addr);
        logic [7:0] val;
        val = r0;
        case (addr)
            REG_LED:     val = r0;
            REG_SCRATCH: val = r1;
            REG_FRMCNT:  val = r2;
            REG_VER:     val = r3;
            default:     val = r0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_rx_sync.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous input.
// Edges are suppressed until the chain holds only post-reset samples.
module spi_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   vld_q, vld_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
        vld_d  = {vld_q[STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    // A pin already active at reset release must not look like a fresh edge.
    assign lvl  = sync_q[STAGES-1];
    assign rise = vld_q[STAGES] &  lvl & ~prev_q;
    assign fall = vld_q[STAGES] & ~lvl &  prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames a command byte followed by data bytes into a
// four-entry register file (LED, scratch, frame counter, version).
//
// state | meaning
// IDLE  | chip select high, waiting for a frame
// CMD   | frame open, next byte is the command
// DATA  | streaming data bytes, pointer auto-increments
// ERR   | bad command, bytes ignored until chip select rises
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VERSION     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce0,
    input  logic       ssig,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [3:0] leds,
    output logic       cmd_err
);

    logic ce0_lvl, ce0_rise, ce0_fall;
    logic ssig_lvl, ssig_rise, ssig_fall;
    logic byte_ev;
    logic unused_ssig;

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ce0),
        .lvl      (ce0_lvl),
        .rise     (ce0_rise),
        .fall     (ce0_fall)
    );

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ssig (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ssig),
        .lvl      (ssig_lvl),
        .rise     (ssig_rise),
        .fall     (ssig_fall)
    );

    assign unused_ssig = ssig_lvl ^ ssig_fall;
    assign byte_ev     = ssig_rise & ~ce0_lvl;

    state_e     state_q, state_d;
    logic [7:0] reg0_q, reg0_d;
    logic [7:0] reg1_q, reg1_d;
    logic [7:0] frmcnt_q, frmcnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic       wr_q, wr_d;
    logic       seen_q, seen_d;
    logic [7:0] tx_q, tx_d;
    logic       err_q, err_d;
    logic [1:0] ptr_nxt;

    assign ptr_nxt = ptr_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        reg0_d   = reg0_q;
        reg1_d   = reg1_q;
        frmcnt_d = frmcnt_q;
        ptr_d    = ptr_q;
        wr_d     = wr_q;
        seen_d   = seen_q;
        tx_d     = tx_q;
        err_d    = err_q;

        // Chip-select release beats any byte arriving in the same cycle.
        if (ce0_rise) begin
            state_d = IDLE;
            err_d   = 1'b0;
            tx_d    = IDLE_BYTE;
            if (state_q == DATA && seen_q)
                frmcnt_d = frmcnt_q + 8'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d = IDLE_BYTE;
                    if (ce0_fall) begin
                        state_d = CMD;
                        seen_d  = 1'b0;
                    end
                end
                CMD: begin
                    tx_d = IDLE_BYTE;
                    if (byte_ev) begin
                        if (rx_byte[6:2] != 5'd0) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                            tx_d    = ERR_BYTE;
                        end else begin
                            state_d = DATA;
                            ptr_d   = rx_byte[1:0];
                            wr_d    = rx_byte[7];
                            seen_d  = 1'b0;
                            tx_d    = rx_byte[7] ? IDLE_BYTE
                                    : reg_mux(reg0_q, reg1_q, frmcnt_q, VERSION, rx_byte[1:0]);
                        end
                    end
                end
                DATA: begin
                    if (byte_ev) begin
                        seen_d = 1'b1;
                        ptr_d  = ptr_nxt;
                        if (wr_q) begin
                            if (ptr_q == REG_LED)     reg0_d = rx_byte;
                            if (ptr_q == REG_SCRATCH) reg1_d = rx_byte;
                        end else begin
                            tx_d = reg_mux(reg0_q, reg1_q, frmcnt_q, VERSION, ptr_nxt);
                        end
                    end
                end
                ERR: begin
                    tx_d  = ERR_BYTE;
                    err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            reg0_q   <= 8'h00;
            reg1_q   <= 8'h00;
            frmcnt_q <= 8'h00;
            ptr_q    <= 2'd0;
            wr_q     <= 1'b0;
            seen_q   <= 1'b0;
            tx_q     <= IDLE_BYTE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg0_q   <= reg0_d;
            reg1_q   <= reg1_d;
            frmcnt_q <= frmcnt_d;
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            seen_q   <= seen_d;
            tx_q     <= tx_d;
            err_q    <= err_d;
        end
    end

    assign tx_byte = tx_q;
    assign leds    = reg0_q[3:0];
    assign cmd_err = err_q;

endmodule
